// File: rtl/dino_pkg.sv
// Shared raster geometry and scheduler state encoding so the VGA timing
// generator and the frame update scheduler agree on frame layout.
package dino_pkg;

    localparam int unsigned H_TOTAL  = 800;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_TOTAL  = 525;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        NEXT = 2'd2,
        DONE = 2'd3
    } sched_state_e;

endpackage

// File: rtl/upd_timer.sv
// Per-request wait counter: cleared while no request is outstanding,
// counts while one is, and flags the last allowed cycle.
module upd_timer #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_c_o
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_c_o = (cnt_q == TW'(TIMEOUT - 1));

endmodule

// File: rtl/frame_update_scheduler.sv
// Issues one ordered request/ack handshake per object at vblank start,
// reporting completion, per-object timeouts and overrun by the next frame.
module frame_update_scheduler #(
    parameter int unsigned NUM_OBJ  = 4,
    parameter int unsigned V_ACTIVE = dino_pkg::V_ACTIVE,
    parameter int unsigned TIMEOUT  = 1024,
    parameter int unsigned FCNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset_btn,
    input  logic [9:0]        vaddress,
    input  logic [9:0]        haddress,
    input  logic              run,
    input  logic [NUM_OBJ-1:0] upd_ack,
    output logic [NUM_OBJ-1:0] upd_req,
    output logic              animate,
    output logic              frame_done,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic [NUM_OBJ-1:0] timeout_flags,
    output logic              overrun,
    output logic              busy
);

    import dino_pkg::*;

    localparam int unsigned IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

    sched_state_e       state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [NUM_OBJ-1:0] upd_req_q, upd_req_d;
    logic               animate_q, animate_d;
    logic               frame_done_q, frame_done_d;
    logic [FCNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [NUM_OBJ-1:0] flags_q, flags_d;
    logic               overrun_q, overrun_d;
    logic               busy_q, busy_d;

    logic start_c;
    logic abort_c;
    logic expire_c;

    assign start_c = (vaddress == 10'(V_ACTIVE)) && (haddress == 10'd0);
    assign abort_c = (vaddress == 10'd0) && (haddress == 10'd0);

    upd_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_upd_timer (
        .clk        (clk),
        .rst_n      (reset_btn),
        .clr_i      (state_q != REQ),
        .en_i       (state_q == REQ),
        .expire_c_o (expire_c)
    );

    // Next state plus next values of every registered output.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        animate_d    = 1'b0;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        flags_d      = flags_q;
        overrun_d    = overrun_q;

        case (state_q)
            IDLE: begin
                if (run && start_c) begin
                    state_d   = REQ;
                    idx_d     = '0;
                    animate_d = 1'b1;
                    flags_d   = '0;
                end
            end
            REQ: begin
                // Abort wins over ack, and ack wins over a coincident expiry.
                if (abort_c) begin
                    state_d   = IDLE;
                    overrun_d = 1'b1;
                end else if (upd_ack[idx_q]) begin
                    state_d = NEXT;
                end else if (expire_c) begin
                    flags_d[idx_q] = 1'b1;
                    state_d        = NEXT;
                end
            end
            NEXT: begin
                if (abort_c) begin
                    state_d   = IDLE;
                    overrun_d = 1'b1;
                end else if (idx_q == IDX_W'(NUM_OBJ - 1)) begin
                    state_d      = DONE;
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + FCNT_W'(1);
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = REQ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        upd_req_d = (state_d == REQ) ? (NUM_OBJ'(1) << idx_d) : '0;
        busy_d    = (state_d == REQ) || (state_d == NEXT);
    end

    always_ff @(posedge clk or negedge reset_btn) begin
        if (!reset_btn) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            upd_req_q    <= '0;
            animate_q    <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            flags_q      <= '0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            upd_req_q    <= upd_req_d;
            animate_q    <= animate_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            flags_q      <= flags_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
        end
    end

    assign upd_req       = upd_req_q;
    assign animate       = animate_q;
    assign frame_done    = frame_done_q;
    assign frame_cnt     = frame_cnt_q;
    assign timeout_flags = flags_q;
    assign overrun       = overrun_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Directed and randomized frames checked against a per-frame model built
// from ack delays: request length, gaps, flags, done pulse and counters.
module tb_frame_update_scheduler;

    localparam int unsigned N  = 4;
    localparam int unsigned TO = 16;
    localparam int unsigned FW = 16;

    logic          clk = 1'b0;
    logic          reset_btn;
    logic [9:0]    vaddress;
    logic [9:0]    haddress;
    logic          run;
    logic [N-1:0]  upd_ack;
    logic [N-1:0]  upd_req;
    logic          animate;
    logic          frame_done;
    logic [FW-1:0] frame_cnt;
    logic [N-1:0]  timeout_flags;
    logic          overrun;
    logic          busy;

    int            ncomp = 0;
    int            nfail = 0;
    logic [FW-1:0] exp_cnt;
    logic          exp_ovr;
    int            dly [N];

    frame_update_scheduler #(
        .NUM_OBJ  (N),
        .V_ACTIVE (480),
        .TIMEOUT  (TO),
        .FCNT_W   (FW)
    ) dut (
        .clk           (clk),
        .reset_btn     (reset_btn),
        .vaddress      (vaddress),
        .haddress      (haddress),
        .run           (run),
        .upd_ack       (upd_ack),
        .upd_req       (upd_req),
        .animate       (animate),
        .frame_done    (frame_done),
        .frame_cnt     (frame_cnt),
        .timeout_flags (timeout_flags),
        .overrun       (overrun),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ncomp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_raster();
        vaddress = 10'd100;
        haddress = 10'd5;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_req"}, 32'(upd_req), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_animate"}, 32'(animate), 32'd0);
        chk({tag, "_done"}, 32'(frame_done), 32'd0);
    endtask

    // One scheduled frame: object k acks on its dly[k]-th request cycle
    // (never if dly[k] >= TO); optional abort at (abort_k, abort_c).
    task automatic run_frame(input int abort_k, input int abort_c, input bit drop_run);
        int          len;
        logic [N-1:0] eflags;
        logic [N-1:0] oh;
        eflags   = '0;
        run      = 1'b1;
        vaddress = 10'd480;
        haddress = 10'd0;
        upd_ack  = N'($urandom);
        step();
        idle_raster();
        chk("start_animate", 32'(animate), 32'd1);
        chk("start_flags_clear", 32'(timeout_flags), 32'd0);
        for (int k = 0; k < N; k++) begin
            len = (dly[k] < int'(TO)) ? dly[k] + 1 : int'(TO);
            oh  = N'(1 << k);
            for (int c = 0; c < len; c++) begin
                chk("req_onehot", 32'(upd_req), 32'(oh));
                chk("req_busy", 32'(busy), 32'd1);
                if (!(k == 0 && c == 0)) chk("animate_once", 32'(animate), 32'd0);
                chk("no_early_done", 32'(frame_done), 32'd0);
                upd_ack = N'($urandom) & ~oh;
                if (c == dly[k]) upd_ack = upd_ack | oh;
                if (k == 1 && c == 0) begin
                    vaddress = 10'd480;
                    haddress = 10'd0;
                    if (drop_run) run = 1'b0;
                end else begin
                    idle_raster();
                end
                if (k == abort_k && c == abort_c) begin
                    vaddress = 10'd0;
                    haddress = 10'd0;
                    upd_ack  = upd_ack & ~oh;
                end
                step();
                if (k == abort_k && c == abort_c) begin
                    exp_ovr = 1'b1;
                    idle_raster();
                    check_quiet("abort");
                    chk("abort_overrun", 32'(overrun), 32'd1);
                    chk("abort_cnt", 32'(frame_cnt), 32'(exp_cnt));
                    chk("abort_flags", 32'(timeout_flags), 32'(eflags));
                    step();
                    check_quiet("abort_idle");
                    return;
                end
            end
            if (dly[k] >= int'(TO)) eflags[k] = 1'b1;
            chk("gap_req", 32'(upd_req), 32'd0);
            chk("gap_busy", 32'(busy), 32'd1);
            upd_ack = N'($urandom);
            idle_raster();
            step();
        end
        exp_cnt = exp_cnt + FW'(1);
        chk("done_pulse", 32'(frame_done), 32'd1);
        chk("done_cnt", 32'(frame_cnt), 32'(exp_cnt));
        chk("done_flags", 32'(timeout_flags), 32'(eflags));
        chk("done_req", 32'(upd_req), 32'd0);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_overrun", 32'(overrun), 32'(exp_ovr));
        step();
        check_quiet("post_done");
        run = 1'b1;
    endtask

    initial begin
        reset_btn = 1'b0;
        run       = 1'b0;
        upd_ack   = '0;
        idle_raster();
        exp_cnt   = '0;
        exp_ovr   = 1'b0;
        #1;
        check_quiet("reset");
        chk("reset_cnt", 32'(frame_cnt), 32'd0);
        chk("reset_flags", 32'(timeout_flags), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        step();
        step();
        reset_btn = 1'b1;
        step();

        dly = '{3, 3, 3, 3};
        run_frame(-1, 0, 1'b0);

        dly = '{1, 100, 0, 2};
        run_frame(-1, 0, 1'b0);

        dly = '{0, 2, 1, int'(TO) - 1};
        run_frame(-1, 0, 1'b0);

        run      = 1'b0;
        vaddress = 10'd480;
        haddress = 10'd0;
        step();
        idle_raster();
        check_quiet("run_off");
        step();
        check_quiet("run_off2");

        dly = '{2, 4, 1, 0};
        run_frame(-1, 0, 1'b1);

        dly = '{0, 0, 100, 0};
        run_frame(2, 7, 1'b0);
        dly = '{1, 0, 2, 1};
        run_frame(-1, 0, 1'b0);

        run      = 1'b1;
        vaddress = 10'd480;
        haddress = 10'd0;
        upd_ack  = '0;
        step();
        idle_raster();
        for (int i = 0; i < 20; i++) begin
            if (upd_req == 4'b0100) break;
            upd_ack = upd_req;
            step();
        end
        chk("reach_idx2", 32'(upd_req), 32'h4);
        upd_ack = '0;
        #2;
        reset_btn = 1'b0;
        #1;
        check_quiet("async_reset");
        chk("async_reset_cnt", 32'(frame_cnt), 32'd0);
        chk("async_reset_overrun", 32'(overrun), 32'd0);
        exp_cnt = '0;
        exp_ovr = 1'b0;
        step();
        reset_btn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            upd_ack = N'($urandom);
            step();
            check_quiet("post_reset");
        end
        upd_ack = '0;

        for (int f = 0; f < 20; f++) begin
            for (int k = 0; k < N; k++) begin
                dly[k] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(14, 20))
                                                     : int'($urandom_range(0, 3));
            end
            run_frame(-1, 0, ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule

// File: doc/frame_update_scheduler.md
# frame_update_scheduler

Sequences the once-per-frame update of game objects (dino, obstacles, score) during vertical blanking. Watches the raster counters from the VGA timing generator and detects the start of vblank. It then issues a one-hot request/acknowledge handshake to each object updater in fixed index order and reports completion, per-object timeouts and frame overruns. It sits between the VGA timing generator and the object modules, and replaces free-running per-object animate strobes with one ordered schedule.

## Interface
- NUM_OBJ, 4, number of object updaters served (1..8)
- V_ACTIVE, 480, first vblank line; sequence starts at vaddress==V_ACTIVE, haddress==0
- TIMEOUT, 1024, max cycles a request may wait for ack (≥2)
- FCNT_W, 16, frame counter width

- clk  in  1  pixel clock, rising edge
- reset_btn  in  1  asynchronous, active-low reset
- vaddress  in  10  current line from VGA timing generator
- haddress  in  10  current pixel from VGA timing generator
- run  in  1  enables scheduling of new frames
- upd_ack  in  NUM_OBJ  per-object done pulse/level; only bit of current index observed
- upd_req  out  NUM_OBJ  one-hot request to current object
- animate  out  1  one-cycle pulse at each accepted sequence start
- frame_done  out  1  one-cycle pulse when all objects served
- frame_cnt  out  FCNT_W  count of completed sequences, wraps
- timeout_flags  out  NUM_OBJ  objects that timed out in last sequence
- overrun  out  1  sticky: a sequence was aborted by next frame start
- busy  out  1  high while in REQ or NEXT

## Operation
- States: IDLE, REQ, NEXT, DONE.
- IDLE: when run=1 and vaddress==V_ACTIVE and haddress==0 → REQ with idx=0; pulse animate; clear timeout_flags; clear timer.
- REQ: upd_req = 1<<idx; timer increments each cycle.
  - upd_ack[idx]=1 → NEXT.
  - Otherwise, timer==TIMEOUT-1 → set timeout_flags[idx], go to NEXT.
  - Ack and expiry in the same cycle: treated as ack; flag not set.
- NEXT: upd_req=0 for one cycle (guarantees a request gap between objects). idx==NUM_OBJ-1 → DONE; else idx+1, timer cleared, → REQ.
- DONE: frame_done pulse, frame_cnt+1 (wraps at 2^FCNT_W), → IDLE.
- Abort: in REQ or NEXT, vaddress==0 and haddress==0 → upd_req=0, overrun=1, → IDLE. No frame_done; frame_cnt unchanged; timeout_flags hold partial result.
- upd_ack bits other than idx are ignored. Ack asserted outside REQ is ignored.
- run is sampled only in IDLE. Deasserting run mid-sequence does not stop the current sequence.
- Start condition while not IDLE is ignored.
- overrun clears only on reset.

## Timing
- Reset values: state IDLE, idx 0, timer 0, upd_req 0, animate 0, frame_done 0, frame_cnt 0, timeout_flags 0, overrun 0, busy 0.
- All outputs are registered.
- Start: the cycle the start condition is sampled is cycle T.
  - animate=1 and upd_req[0]=1 from T+1.
  - animate lasts one cycle.
- Ack sampled at cycle A drops upd_req at A+1 (NEXT). The next request rises at A+2.
- Per-object cost with immediate ack: 2 cycles. Best-case sequence: 2·NUM_OBJ cycles plus 1 for DONE.
- Timeout: upd_req[idx] is high for exactly TIMEOUT cycles, then NEXT.
- frame_done is high for one cycle, the cycle after the last NEXT.

## Structure
- Shared package dino_pkg holds:
  - the state enum (IDLE/REQ/NEXT/DONE)
  - H_TOTAL=800, V_ACTIVE=480, V_TOTAL=525, so timing generator and scheduler agree
- Sub-module upd_timer contains the TIMEOUT counter, with clear/enable inputs and an expire output.
- Everything else lives in one FSM module.

## Test plan
- Reset mid-REQ (idx=2): asserting reset_btn low → all outputs 0 immediately; after release, no requests until the next vblank start.
- Normal frame, NUM_OBJ=4, each ack 3 cycles after req → upd_req sequence 0001,0010,0100,1000 with 1-cycle gaps; one frame_done; frame_cnt 0→1; timeout_flags=0.
- Object 1 never acks, TIMEOUT=16 → upd_req[1] high exactly 16 cycles; timeout_flags=4'b0010; sequence completes.
- Ack on the same cycle as timer expiry for object 3 → flag 3 stays 0.
- run=0 at vblank start → no animate, no req. run dropped during idx=1 → sequence finishes normally.
- Object 2 stalls, TIMEOUT=60000, raster reaches vaddress=0, haddress=0 → req dropped, overrun=1, frame_cnt unchanged; the next frame starts cleanly.
